// File: rtl/mem_arbiter.sv
// Shares one single-cycle memory between an instruction-fetch port and a data port.
// Data wins ties until fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3,
  parameter logic [31:0] ADDR_LIMIT   = 32'h100
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,

  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam int unsigned CNT_W = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_starved;
  logic             grant_i;
  logic             grant_d;
  logic             i_addr_err;
  logic             d_addr_err;

  // Misaligned or beyond the end of the memory.
  function automatic logic addr_error(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr >= ADDR_LIMIT);
  endfunction

  assign i_addr_err = addr_error(i_addr);
  assign d_addr_err = addr_error(d_addr);

  always_comb begin
    fetch_starved = (starve_cnt == CNT_MAX);
    grant_i       = 1'b0;
    grant_d       = 1'b0;
    if (reset_n) begin
      if (i_req && d_req) begin
        grant_i = fetch_starved;
        grant_d = !fetch_starved;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  assign i_gnt = grant_i;
  assign d_gnt = grant_d;

  // A rejected store must never reach the memory, so the address check gates mem_we.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    if (grant_i) begin
      mem_a = i_addr;
    end else if (grant_d) begin
      mem_a  = d_addr;
      mem_wd = d_wdata;
      mem_we = d_we && !d_addr_err;
    end
  end

  // Counts data grants that overtook a waiting fetch; any other cycle clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (grant_d && i_req) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_rvalid <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
    end else begin
      i_rvalid <= grant_i;
      if (grant_i) begin
        i_err   <= i_addr_err;
        i_rdata <= i_addr_err ? '0 : mem_rd;
      end
    end
  end

  // Stores also get a response pulse, always with zero read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
    end else begin
      d_rvalid <= grant_d;
      if (grant_d) begin
        d_err   <= d_addr_err;
        d_rdata <= (d_addr_err || d_we) ? '0 : mem_rd;
      end
    end
  end

endmodule
